// File: rtl/framebuf_pkg.sv
// Shared constants and state encoding for the LED frame buffer loader.
package framebuf_pkg;

  localparam int unsigned DEFAULT_NUM_LEDS      = 16;
  localparam int unsigned DEFAULT_BYTES_PER_LED = 3;

  localparam int unsigned FB_BYTES = DEFAULT_NUM_LEDS * DEFAULT_BYTES_PER_LED;
  localparam int unsigned FB_WIDTH = 8 * FB_BYTES;
  localparam int unsigned IDX_W    = $clog2(FB_BYTES);

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    COMMIT = 1'b1
  } state_e;

endpackage

// File: rtl/framebuf_loader_pixel_scale.sv
// Brightness scaler: stored = (data * (brightness + 1)) >> 8, so 0xFF is identity.
module pixel_scale
  import framebuf_pkg::*;
(
  input  logic [7:0] data,
  input  logic [7:0] brightness,
  output logic [7:0] scaled
);

  logic [8:0]  gain;
  logic [15:0] product;

  assign gain    = {1'b0, brightness} + 9'd1;
  assign product = 16'(data) * 16'(gain);
  assign scaled  = 8'(product >> 8);

endmodule

// File: rtl/framebuf_loader.sv
// Assembles a byte stream into a back buffer and commits whole frames to the front buffer.
// Optional per-byte brightness scaling is enabled by defining FRAMEBUF_BRIGHTNESS_EN.
module framebuf_loader
  import framebuf_pkg::*;
#(
  parameter  int unsigned NUM_LEDS      = DEFAULT_NUM_LEDS,
  parameter  int unsigned BYTES_PER_LED = DEFAULT_BYTES_PER_LED,
  localparam int unsigned FbBytes       = NUM_LEDS * BYTES_PER_LED,
  localparam int unsigned FbWidth       = 8 * FbBytes,
  localparam int unsigned IdxW          = $clog2(FbBytes)
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [7:0]         wr_data,
  input  logic               wr_valid,
  input  logic               wr_first,
`ifdef FRAMEBUF_BRIGHTNESS_EN
  input  logic [7:0]         brightness,
`endif
  output logic               wr_ready,
  output logic [FbWidth-1:0] framebuf,
  output logic               frame_done,
  output logic               err_short,
  output logic [IdxW-1:0]    byte_idx
);

  state_e             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [FbWidth-1:0] back_q, back_d;
  logic [FbWidth-1:0] front_q, front_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               accept;
  logic [IdxW-1:0]    eff_idx;
  logic               last_byte;
  logic [7:0]         store_byte;

`ifdef FRAMEBUF_BRIGHTNESS_EN
  pixel_scale u_pixel_scale (
    .data       (wr_data),
    .brightness (brightness),
    .scaled     (store_byte)
  );
`else
  assign store_byte = wr_data;
`endif

  assign accept    = wr_valid && ready_q;
  // wr_first restarts the frame at byte 0 regardless of the current fill level.
  assign eff_idx   = wr_first ? '0 : idx_q;
  assign last_byte = (eff_idx == IdxW'(FbBytes - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    back_d  = back_q;
    front_d = front_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      FILL: begin
        ready_d = 1'b1;
        if (accept) begin
          back_d[8*eff_idx +: 8] = store_byte;
          err_d                  = wr_first && (idx_q != '0);
          if (last_byte) begin
            idx_d   = '0;
            state_d = COMMIT;
            ready_d = 1'b0;
          end else begin
            idx_d = eff_idx + 1'b1;
          end
        end
      end
      COMMIT: begin
        // Single-edge copy keeps the serialiser from ever seeing a partial frame.
        front_d = back_q;
        done_d  = 1'b1;
        idx_d   = '0;
        ready_d = 1'b1;
        state_d = FILL;
      end
      default: begin
        state_d = FILL;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= FILL;
      idx_q   <= '0;
      back_q  <= '0;
      front_q <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      back_q  <= back_d;
      front_q <= front_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign wr_ready   = ready_q;
  assign framebuf   = front_q;
  assign frame_done = done_q;
  assign err_short  = err_q;
  assign byte_idx   = idx_q;

endmodule

// File: tb/tb_framebuf_loader.sv
// Directed, table-driven bench for framebuf_loader with a small frame model.
module tb_framebuf_loader;
  import framebuf_pkg::*;

  localparam int unsigned W = FB_WIDTH;

  logic             clk;
  logic             nrst;
  logic [7:0]       wr_data;
  logic             wr_valid;
  logic             wr_first;
  logic             wr_ready;
  logic [W-1:0]     framebuf;
  logic             frame_done;
  logic             err_short;
  logic [IDX_W-1:0] byte_idx;
`ifdef FRAMEBUF_BRIGHTNESS_EN
  logic [7:0]       brightness;
`endif

  framebuf_loader dut (
    .clk        (clk),
    .nrst       (nrst),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_first   (wr_first),
`ifdef FRAMEBUF_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .wr_ready   (wr_ready),
    .framebuf   (framebuf),
    .frame_done (frame_done),
    .err_short  (err_short),
    .byte_idx   (byte_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]   back_m [FB_BYTES];
  logic [W-1:0] front_m;
  int           m_idx;

  typedef struct {
    logic [7:0]       data;
    logic             first;
    logic [IDX_W-1:0] exp_idx;
    logic             exp_err;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < FB_BYTES; k++) back_m[k] = 8'h00;
    front_m = '0;
    m_idx   = 0;
  endtask

  // Drives one byte for one clock; the DUT must be ready when it is presented.
  task automatic send_byte(input logic [7:0] d, input logic first);
    int eff;
    check("ready_before_send", W'(wr_ready), W'(1));
    wr_data  = d;
    wr_first = first;
    wr_valid = 1'b1;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    wr_first = 1'b0;
    eff = first ? 0 : m_idx;
    back_m[eff] = d;
    m_idx = eff + 1;
    if (m_idx == FB_BYTES) m_idx = 0;
  endtask

  // Called in the cycle after the last byte of a frame was accepted.
  task automatic finish_commit();
    check("ready_low_in_commit", W'(wr_ready), W'(0));
    check("done_not_early", W'(frame_done), W'(0));
    @(posedge clk);
    #1;
    for (int k = 0; k < FB_BYTES; k++) front_m[8*k +: 8] = back_m[k];
    check("frame_done_pulse", W'(frame_done), W'(1));
    check("ready_after_commit", W'(wr_ready), W'(1));
    check("framebuf_commit", framebuf, front_m);
    check("idx_after_commit", W'(byte_idx), W'(0));
    @(posedge clk);
    #1;
    check("frame_done_single", W'(frame_done), W'(0));
  endtask

  initial begin
    logic [W-1:0] all_ones;
    all_ones = '1;

    for (int i = 0; i < 10; i++) begin
      tbl[i].data    = 8'(8'h10 + i);
      tbl[i].first   = (i == 0);
      tbl[i].exp_idx = IDX_W'(i + 1);
      tbl[i].exp_err = 1'b0;
    end
    tbl[10] = '{data: 8'hAA, first: 1'b1, exp_idx: 6'd1, exp_err: 1'b1};
    tbl[11] = '{data: 8'hAB, first: 1'b0, exp_idx: 6'd2, exp_err: 1'b0};

    nrst     = 1'b0;
    wr_data  = 8'h00;
    wr_valid = 1'b0;
    wr_first = 1'b0;
`ifdef FRAMEBUF_BRIGHTNESS_EN
    brightness = 8'hFF;
`endif
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_framebuf", framebuf, '0);
    check("rst_ready", W'(wr_ready), W'(0));
    check("rst_done", W'(frame_done), W'(0));
    check("rst_err", W'(err_short), W'(0));
    nrst = 1'b1;
    @(posedge clk);
    #1;
    check("release_ready", W'(wr_ready), W'(1));
    check("release_idx", W'(byte_idx), W'(0));

    // Back-to-back frame 0x00..0x2F
    for (int k = 0; k < FB_BYTES; k++) send_byte(8'(k), k == 0);
    finish_commit();
    for (int k = 0; k < FB_BYTES; k++) check("ramp_byte", W'(framebuf[8*k +: 8]), W'(k));

    // Truncated frame restarted by wr_first
    for (int i = 0; i < 12; i++) begin
      send_byte(tbl[i].data, tbl[i].first);
      check("tbl_idx", W'(byte_idx), W'(tbl[i].exp_idx));
      check("tbl_err", W'(err_short), W'(tbl[i].exp_err));
      check("tbl_framebuf_held", framebuf, front_m);
      check("tbl_no_done", W'(frame_done), W'(0));
    end
    for (int k = 0; k < 46; k++) begin
      send_byte(8'(8'h80 + k), 1'b0);
      if (k == 44) check("held_before_last", framebuf, front_m);
    end
    finish_commit();
    check("restart_byte0", W'(framebuf[7:0]), W'(8'hAA));
    check("restart_byte1", W'(framebuf[15:8]), W'(8'hAB));

    // Gapped valid, 48 x 0xFF
    for (int k = 0; k < FB_BYTES; k++) begin
      send_byte(8'hFF, k == 0);
      if (k == 0) check("first_at_zero_no_err", W'(err_short), W'(0));
      if (k < FB_BYTES - 1) begin
        check("gap_idx_accept", W'(byte_idx), W'(k + 1));
        @(posedge clk);
        #1;
        check("gap_idx_hold", W'(byte_idx), W'(k + 1));
      end
    end
    finish_commit();
    check("all_ones", framebuf, all_ones);

    // Reset mid-frame
    for (int k = 0; k < 30; k++) send_byte(8'(8'h40 + k), k == 0);
    check("idx_before_reset", W'(byte_idx), W'(30));
    nrst = 1'b0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    model_reset();
    check("midrst_framebuf", framebuf, '0);
    check("midrst_idx", W'(byte_idx), W'(0));
    check("midrst_ready", W'(wr_ready), W'(0));
    @(posedge clk);
    #1;
    check("midrst_ready_back", W'(wr_ready), W'(1));
    for (int k = 0; k < FB_BYTES; k++) send_byte(8'(8'hC0 + k), k == 0);
    finish_commit();

`ifdef FRAMEBUF_BRIGHTNESS_EN
    brightness = 8'h7F;
    send_byte(8'hFF, 1'b1);
    back_m[0] = 8'h7F;
    brightness = 8'hFF;
    send_byte(8'hFF, 1'b0);
    brightness = 8'h00;
    send_byte(8'hFF, 1'b0);
    back_m[2] = 8'h00;
    brightness = 8'hFF;
    for (int k = 3; k < FB_BYTES; k++) send_byte(8'hFF, 1'b0);
    finish_commit();
    check("bright_7f", W'(framebuf[7:0]), W'(8'h7F));
    check("bright_ff", W'(framebuf[15:8]), W'(8'hFF));
    check("bright_00", W'(framebuf[23:16]), W'(8'h00));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
